fetch_prefetch_queue: RTL
=========================

// Module: fetch_prefetch_queue
// PURPOSE
//  Parametrised in-order instruction prefetcher between the PC/IF stage and the instruction cache.
//  Runs ahead of the decoder, keeping up to MAX_OUTSTANDING cache reads in flight and buffering
//  returned {addr,inst} pairs in a DEPTH-entry queue. On jump/jtag reset it flushes the queue and
//  discards every in-flight response in hardware. Replaces the two-FIFO pc_/fetch_cache pairing.
// PARAMETERS
//  ADDR_W           32        instruction address width
//  DATA_W           32        instruction width
//  DEPTH            8         instruction queue entries; power of 2, >=2
//  MAX_OUTSTANDING  4         max accepted-but-unanswered cache reads, 1..DEPTH
//  RESET_PC         32'h0     fetch address after reset / jtag reset
//  PC_STEP          4         sequential fetch increment
// PORTS
//  clk                 in   1       clock
//  rst                 in   1       synchronous reset, active-high
//  jtag_reset_flag_i   in   1       flush, restart at RESET_PC
//  jump_flag_i         in   1       flush, restart at jump_addr_i
//  jump_addr_i         in   ADDR_W  redirect target
//  hold_flag_i         in   3       `Hold_Flag_Bus; advance only when == `Hold_None
//  inst_addr_o         out  ADDR_W  address of presented instruction
//  inst_o              out  DATA_W  presented instruction (`INST_NOP when none)
//  inst_valid_o        out  1       inst_o is a real fetched instruction
//  o_p_addr            out  ADDR_W  cache read address
//  o_p_read            out  1       cache read request
//  o_p_byte_en         out  DATA_W/8  constant all-ones
//  o_p_write/o_p_writedata  out 1/DATA_W  constant 0
//  i_p_readdata        in   DATA_W  cache read data
//  i_p_readdata_valid  in   1       one in-order response per accepted read
//  i_p_waitrequest     in   1       request stalled this cycle
// BEHAVIOUR
//  Reset (rst=1 at posedge): o_p_read=0, o_p_addr=RESET_PC, fetch_pc=RESET_PC, queue empty,
//   inflight=0, stale=0, inst_o=`INST_NOP, inst_addr_o=RESET_PC, inst_valid_o=0. Reset wins over all.
//  Issue: o_p_read=1 iff inflight+occupancy < DEPTH and inflight < MAX_OUTSTANDING, or a request
//   is held. Accept = o_p_read & ~i_p_waitrequest. While waitrequest=1, o_p_addr/o_p_read held
//   stable, even across a flush. On accept: inflight++, fetch_pc += PC_STEP (wraps modulo 2^ADDR_W).
//  Tag queue: accepted addresses pushed into MAX_OUTSTANDING-deep address queue; response pops it.
//  Response: if stale==0, push {tag addr, readdata} into queue, else drop and stale--. inflight--.
//   Accept and response in same cycle: inflight unchanged. Response with inflight==0: protocol
//   error, ignored (assertion).
//  Flush (jump_flag_i | jtag_reset_flag_i; jtag has priority on target): queue emptied,
//   stale <= inflight + accept - resp_this_cycle (all in-flight, incl. same-cycle accept, stale;
//   a same-cycle response is itself dropped), tag queue cleared, fetch_pc <= target.
//   Held request at flush: kept asserted with old address until accepted, marked stale
//   (stale++ on its accept); next request then uses target. Flush-cycle output: inst_o=`INST_NOP,
//   inst_valid_o=0, regardless of hold. Consecutive flushes accumulate stale correctly.
//  Output (registered, 1-cycle): when hold_flag_i==`Hold_None and no flush: if queue non-empty pop
//   head to outputs, inst_valid_o=1; else inst_o=`INST_NOP, inst_valid_o=0, inst_addr_o unchanged.
//   Hold: outputs and queue head frozen; fetch continues until credits exhausted.
//  Full: no issue when inflight+occupancy==DEPTH, so response never meets full queue (assertion).
//  Simultaneous push & pop at occupancy DEPTH or 0: both honoured.
//  Latency: cache hit 1 cycle -> 2 cycles accept-to-inst_o when not held, queue empty.
// STRUCTURE
//  `INST_NOP (32'h00000013), `Hold_None, `Hold_Flag_Bus stay in shared defines.v.
//  Sub-module: sync_fifo (existing, synchronous flush via rst_n) for the {addr,inst} queue,
//  ASIZE=$clog2(DEPTH), DSIZE=ADDR_W+DATA_W. Tag queue, counters, issue logic local.
// TESTING
//  1 Reset release, 1-cycle-hit cache, hold=None -> reads 0x0,0x4,0x8..; inst_valid_o=1 from cycle 3, no gaps.
//  2 waitrequest=1 for 5 cycles on addr 0x8 -> o_p_addr stays 0x8, o_p_read stays 1; no dup fetch.
//  3 3-cycle cache latency, jump to 0x100 with 3 in flight -> 3 responses dropped, first valid inst_addr_o=0x100.
//  4 hold=`Hold_Pc 20 cycles -> exactly DEPTH=8 reads issued, outputs frozen; release -> 8 in order, no loss.
//  5 jump to 0x200 while 0x40 held by waitrequest, then jump 0x300 -> 0x40 stays, both stale; first valid 0x300.
//  6 rst pulse with 2 in flight, occupancy 5 -> all outputs at reset values next cycle; restart from RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared constants for the instruction prefetcher: NOP encoding, pipeline
// hold codes and a small wrap-around pointer helper.
// Values mirror the core-wide defines so hold/NOP encodings stay consistent.
package fetch_prefetch_queue_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0) presented when no instruction is ready
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Pipeline hold bus width and encodings
  localparam int HOLD_W = 3;

  typedef enum logic [HOLD_W-1:0] {
    HOLD_NONE = 3'b000,
    HOLD_PC   = 3'b001,
    HOLD_IF   = 3'b010,
    HOLD_ID   = 3'b011
  } hold_e;

  // Increment a circular-buffer pointer over n entries (n need not be a power of 2)
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: generic show-ahead synchronous FIFO, 2**ASIZE entries of DSIZE bits.
// Latency: write visible on rdata the cycle after it is accepted; rdata is the head combinationally.
// Backpressure: writes ignored when full unless a read frees a slot the same cycle; reads ignored when empty.
module sync_fifo #(
  parameter int ASIZE = 3,
  parameter int DSIZE = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [ASIZE:0]   count
);

  localparam int DEPTH = 1 << ASIZE;
  localparam int CW    = ASIZE + 1;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] wptr;
  logic [ASIZE-1:0] rptr;
  logic             do_wr;
  logic             do_rd;

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | rd_en);
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // Pointer and occupancy tracking; rst_n doubles as a synchronous flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  // Storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Purpose: in-order instruction prefetcher keeping up to MAX_OUTSTANDING cache reads in flight ahead of decode.
// Latency: 1-cycle cache hit gives inst_o two cycles after the read is accepted (empty queue, no hold).
// Backpressure: issue stops when in-flight + queued reaches DEPTH; waitrequest freezes the request; hold freezes outputs.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 32,
  parameter int                DEPTH           = 8,
  parameter int                MAX_OUTSTANDING = 4,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0,
  parameter int                PC_STEP         = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jtag_reset_flag_i,
  input  logic                jump_flag_i,
  input  logic [ADDR_W-1:0]   jump_addr_i,
  input  logic [HOLD_W-1:0]   hold_flag_i,
  output logic [ADDR_W-1:0]   inst_addr_o,
  output logic [DATA_W-1:0]   inst_o,
  output logic                inst_valid_o,
  output logic [ADDR_W-1:0]   o_p_addr,
  output logic                o_p_read,
  output logic [DATA_W/8-1:0] o_p_byte_en,
  output logic                o_p_write,
  output logic [DATA_W-1:0]   o_p_writedata,
  input  logic [DATA_W-1:0]   i_p_readdata,
  input  logic                i_p_readdata_valid,
  input  logic                i_p_waitrequest
);

  localparam int ASIZE  = $clog2(DEPTH);
  localparam int CNT_W  = ASIZE + 1;
  localparam int SUM_W  = CNT_W + 1;
  localparam int TAG_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [DATA_W-1:0] NOP    = DATA_W'(INST_NOP);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] inst;
  } q_entry_t;

  // Request / credit state
  logic [ADDR_W-1:0] fetch_pc;
  logic              held;
  logic              held_stale;
  logic [ADDR_W-1:0] held_addr;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  stale;
  logic [CNT_W-1:0]  occupancy;
  logic [SUM_W-1:0]  committed;
  logic              can_issue;

  // Per-cycle events
  logic              flush;
  logic [ADDR_W-1:0] flush_target;
  logic              accept;
  logic              acc_stale;
  logic              resp;
  logic              resp_live;
  logic              q_push;
  logic              q_pop;
  logic              tag_push;
  logic              tag_pop;
  logic              fifo_rst_n;

  // Address tag queue for outstanding live reads
  logic [ADDR_W-1:0] tag_mem [MAX_OUTSTANDING];
  logic [TAG_AW-1:0] tag_wr;
  logic [TAG_AW-1:0] tag_rd;

  // Instruction queue interface
  q_entry_t          push_entry;
  q_entry_t          head;
  logic              q_full;
  logic              q_empty;

  assign flush        = jump_flag_i | jtag_reset_flag_i;
  assign flush_target = jtag_reset_flag_i ? RESET_PC : jump_addr_i;

  // Every accepted read, stale or not, holds a slot until its response returns
  assign committed = {1'b0, inflight} + {1'b0, occupancy};
  assign can_issue = (committed < DEPTH_C) && (inflight < MAX_C);

  // A stalled request keeps its address even if a redirect arrives meanwhile
  assign o_p_read = held | (~rst & can_issue);
  assign o_p_addr = held ? held_addr : fetch_pc;

  assign accept    = o_p_read & ~i_p_waitrequest;
  assign acc_stale = held & held_stale;

  // A response with nothing outstanding is a cache protocol violation and is ignored
  assign resp      = i_p_readdata_valid & (inflight != '0);
  assign resp_live = resp & (stale == '0);

  assign q_push    = resp_live & ~flush;
  assign q_pop     = (hold_flag_i == HOLD_NONE) & ~flush & ~q_empty;
  assign tag_push  = accept & ~acc_stale & ~flush;
  assign tag_pop   = resp_live & ~flush;
  assign fifo_rst_n = ~(rst | flush);

  assign push_entry = '{addr: tag_mem[tag_rd], inst: i_p_readdata};

  assign o_p_byte_en   = '1;
  assign o_p_write     = 1'b0;
  assign o_p_writedata = '0;

  // Fetch PC and the stalled-request holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      held       <= 1'b0;
      held_stale <= 1'b0;
      held_addr  <= RESET_PC;
    end else begin
      held       <= o_p_read & i_p_waitrequest;
      held_addr  <= o_p_addr;
      held_stale <= o_p_read & i_p_waitrequest & (flush | (held & held_stale));
      if (flush) begin
        fetch_pc <= flush_target;
      end else if (accept && !acc_stale) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
    end
  end

  // In-flight and stale counters; on flush everything still outstanding becomes stale
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      stale    <= '0;
    end else begin
      inflight <= inflight + CNT_W'(accept) - CNT_W'(resp);
      if (flush) begin
        stale <= inflight + CNT_W'(accept) - CNT_W'(resp);
      end else begin
        stale <= stale + CNT_W'(accept & acc_stale) - CNT_W'(resp & (stale != '0));
      end
    end
  end

  // Tag queue pointers, cleared together with the instruction queue on flush
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (tag_push) tag_wr <= TAG_AW'(wrap_inc(int'(tag_wr), MAX_OUTSTANDING));
      if (tag_pop)  tag_rd <= TAG_AW'(wrap_inc(int'(tag_rd), MAX_OUTSTANDING));
    end
  end

  // Tag storage: address of each live accepted read
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wr] <= o_p_addr;
  end

  sync_fifo #(
    .ASIZE (ASIZE),
    .DSIZE (ADDR_W + DATA_W)
  ) u_inst_q (
    .clk   (clk),
    .rst_n (fifo_rst_n),
    .wr_en (q_push),
    .wdata (push_entry),
    .rd_en (q_pop),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (occupancy)
  );

  // Present the queue head, one instruction per unheld cycle; hold freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_o       <= NOP;
      inst_addr_o  <= RESET_PC;
      inst_valid_o <= 1'b0;
    end else if (flush) begin
      inst_o       <= NOP;
      inst_valid_o <= 1'b0;
    end else if (hold_flag_i == HOLD_NONE) begin
      if (!q_empty) begin
        inst_o       <= head.inst;
        inst_addr_o  <= head.addr;
        inst_valid_o <= 1'b1;
      end else begin
        inst_o       <= NOP;
        inst_valid_o <= 1'b0;
      end
    end
  end

  a_resp_has_owner: assert property (@(posedge clk) disable iff (rst)
    i_p_readdata_valid |-> (inflight != '0));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    q_push |-> !q_full);

endmodule
